kernel_cc_start_fifo_ctrl: RTL and testbench
============================================

// Module: kernel_cc_start_fifo_ctrl
// PURPOSE
//  Parametrised shift-register start/token FIFO for dataflow stage hand-off in kernel_cc.
//  Keeps the if_* ready/valid handshake of the existing start FIFOs and adds:
//   - occupancy count output
//   - almost-full / almost-empty flags
//   - accept-on-full when read and write occur in the same cycle
//   - sticky overflow / underflow error flags
//  Sits between a producer stage's start/done and a consumer stage's ap_start.
// PARAMETERS
//  DATA_WIDTH  1  token width in bits
//  ADDR_WIDTH  2  SRL address width; must satisfy 2**ADDR_WIDTH >= DEPTH
//  DEPTH       4  storage entries; must be >= 2
//  AF_LEVEL    3  if_almost_full asserted when count >= AF_LEVEL; AE_LEVEL < AF_LEVEL <= DEPTH
//  AE_LEVEL    1  if_almost_empty asserted when count <= AE_LEVEL; AE_LEVEL >= 0
//  FULL_RW_EN  1  1: a write while full is accepted if a read is accepted in the same cycle
// PORTS
//  clk              in   1             clock; all logic on rising edge
//  reset            in   1             synchronous, active-high reset
//  if_din           in   DATA_WIDTH    write data
//  if_write         in   1             write request
//  if_write_ce      in   1             write clock-enable; write is wr = if_write & if_write_ce
//  if_full_n        out  1             1 = space available
//  if_dout          out  DATA_WIDTH    head-of-queue data; valid while if_empty_n = 1
//  if_read          in   1             read request
//  if_read_ce       in   1             read clock-enable; read is rd = if_read & if_read_ce
//  if_empty_n       out  1             1 = data available
//  if_count         out  ADDR_WIDTH+1  entries currently stored, 0..DEPTH
//  if_almost_full   out  1             count >= AF_LEVEL
//  if_almost_empty  out  1             count <= AE_LEVEL
//  if_ovf           out  1             sticky: a write was refused
//  if_udf           out  1             sticky: a read was issued while empty
//  err_clr          in   1             clears if_ovf and if_udf
// BEHAVIOUR
//  - Accept rules:
//    - rd_acc = rd & if_empty_n
//    - wr_acc = wr & (if_full_n | (FULL_RW_EN & rd_acc))
//  - Storage: DEPTH-entry shift register, shifted only when wr_acc.
//    - Entry 0 receives if_din; entry i+1 receives entry i.
//    - Contents are not reset.
//  - Count update (single register):
//    - count + 1 when wr_acc & !rd_acc
//    - count - 1 when rd_acc & !wr_acc
//    - unchanged otherwise
//  - Head read: if_dout = SRL[count-1] when count > 0, else SRL[0]. Combinational from registers.
//  - Flags are registered and computed from next_count, so they are exact in the cycle after any update:
//    - if_empty_n = (next_count != 0)
//    - if_full_n = (next_count != DEPTH)
//    - if_almost_full = (next_count >= AF_LEVEL)
//    - if_almost_empty = (next_count <= AE_LEVEL)
//  - Latency: write into an empty FIFO -> if_empty_n = 1 and if_dout valid on the next cycle (1-cycle fall-through).
//  - Read-then-full: a read on a full FIFO raises if_full_n in the next cycle.
//  - Simultaneous read+write on a full FIFO:
//    - FULL_RW_EN = 1: both accepted; count stays DEPTH; if_full_n stays 0; the next-oldest entry becomes head.
//    - FULL_RW_EN = 0: only the read is accepted; the write counts as refused.
//  - Simultaneous read+write on an empty FIFO: write accepted, read refused (underflow); count becomes 1.
//  - Error flags:
//    - if_ovf is set on wr & !wr_acc.
//    - if_udf is set on rd & !if_empty_n.
//    - Both are sticky until err_clr. If err_clr and a new error occur in the same cycle, the error wins (flag = 1).
//  - Refused operations never change count or storage.
//  - Reset (sync, at any time, including mid-transfer) forces:
//    - count = 0, if_empty_n = 0, if_full_n = 1
//    - if_almost_full = 0, if_almost_empty = 1
//    - if_ovf = 0, if_udf = 0
//    - Stored data is discarded (logically invisible).
//  - Width rules: count is ADDR_WIDTH+1 bits; it never wraps because the accept rules bound it to 0..DEPTH.
// TESTING
//  1. Defaults; write 1,2,3,4 on consecutive cycles, no reads
//     -> count 1..4; if_almost_full rises the cycle after the 3rd write; if_full_n = 0 after the 4th;
//        then read 4 cycles -> if_dout 1,2,3,4; if_empty_n = 0 after the last read.
//  2. Full (1,2,3,4); rd and wr (din = 5) in the same cycle, FULL_RW_EN = 1
//     -> count 4, if_full_n 0, if_dout = 2; draining yields 2,3,4,5.
//  3. Full; wr with no rd -> if_ovf = 1 next cycle, count 4, contents intact;
//     err_clr for 1 cycle -> if_ovf = 0; err_clr coincident with another refused wr -> if_ovf stays 1.
//  4. Empty; rd and wr (din = 7) together -> if_udf = 1, count 1, if_empty_n = 1 next cycle, if_dout = 7.
//  5. Count = 3, assert reset during an active wr+rd
//     -> next cycle count 0, if_empty_n 0, if_full_n 1, if_almost_empty 1, flags 0;
//        a new write of 9 then reads back 9.
//  6. FULL_RW_EN = 0, DEPTH = 8, ADDR_WIDTH = 3, AF_LEVEL = 6, AE_LEVEL = 2:
//     fill to 8 -> if_almost_empty falls at count 3, if_almost_full rises at count 6;
//     rd+wr while full -> count 7, if_ovf = 1.

Source files
------------

// File: rtl/kernel_cc_start_fifo_ctrl.sv
// Shift-register start/token FIFO for dataflow stage hand-off, with occupancy,
// almost-full/almost-empty flags, accept-on-full read+write and sticky error flags.
module kernel_cc_start_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1,
  parameter int FULL_RW_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_ovf,
  output logic                  if_udf,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);
  localparam logic                FRW_C   = (FULL_RW_EN != 0);

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   next_count;
  logic [ADDR_WIDTH:0]   count_m1;
  logic                  wr, rd, rd_acc, wr_acc;

  // Handshake: a write transfers when wr & (if_full_n | (FULL_RW_EN & rd_acc));
  // a read transfers when rd & if_empty_n. Anything else is refused and only
  // sets the matching sticky error flag; count and storage are left untouched.
  assign wr     = if_write & if_write_ce;
  assign rd     = if_read & if_read_ce;
  assign rd_acc = rd & if_empty_n;
  assign wr_acc = wr & (if_full_n | (FRW_C & rd_acc));

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      srl[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
  end

  // Oldest entry sits at the deepest occupied slot.
  assign count_m1 = count - ONE_C;
  assign if_dout  = (count != '0) ? srl[count_m1[ADDR_WIDTH-1:0]] : srl[0];
  assign if_count = count;

  always_comb begin
    next_count = count;
    case ({wr_acc, rd_acc})
      2'b10:   next_count = count + ONE_C;
      2'b01:   next_count = count - ONE_C;
      default: next_count = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count           <= '0;
      if_empty_n      <= 1'b0;
      if_full_n       <= 1'b1;
      if_almost_full  <= 1'b0;
      if_almost_empty <= 1'b1;
      if_ovf          <= 1'b0;
      if_udf          <= 1'b0;
    end else begin
      count           <= next_count;
      if_empty_n      <= (next_count != '0);
      if_full_n       <= (next_count != DEPTH_C);
      if_almost_full  <= (next_count >= AF_C);
      if_almost_empty <= (next_count <= AE_C);
      // A new error in the same cycle as err_clr keeps the flag set.
      if_ovf          <= (wr & ~wr_acc) | (if_ovf & ~err_clr);
      if_udf          <= (rd & ~if_empty_n) | (if_udf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_kernel_cc_start_fifo_ctrl.sv
// Bench for kernel_cc_start_fifo_ctrl: table-driven vectors on a DEPTH=4 instance
// with a data scoreboard, plus a hand-written sequence on a DEPTH=8, FULL_RW_EN=0 instance.
module tb_kernel_cc_start_fifo_ctrl;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic          reset, wr, rd, clr;
  logic [DW-1:0] din;
  logic          full_n, empty_n, af, ae, ovf, udf;
  logic [DW-1:0] dout;
  logic [2:0]    count;

  kernel_cc_start_fifo_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .if_din(din), .if_write(wr), .if_write_ce(1'b1),
    .if_full_n(full_n), .if_dout(dout), .if_read(rd), .if_read_ce(1'b1),
    .if_empty_n(empty_n), .if_count(count), .if_almost_full(af),
    .if_almost_empty(ae), .if_ovf(ovf), .if_udf(udf), .err_clr(clr)
  );

  // DEPTH=8, FULL_RW_EN=0 instance
  logic          reset8, wr8, rd8, clr8;
  logic [DW-1:0] din8;
  logic          full_n8, empty_n8, af8, ae8, ovf8, udf8;
  logic [DW-1:0] dout8;
  logic [3:0]    count8;

  kernel_cc_start_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .DEPTH(8), .AF_LEVEL(6),
                              .AE_LEVEL(2), .FULL_RW_EN(0)) dut8 (
    .clk(clk), .reset(reset8), .if_din(din8), .if_write(wr8), .if_write_ce(1'b1),
    .if_full_n(full_n8), .if_dout(dout8), .if_read(rd8), .if_read_ce(1'b1),
    .if_empty_n(empty_n8), .if_count(count8), .if_almost_full(af8),
    .if_almost_empty(ae8), .if_ovf(ovf8), .if_udf(udf8), .err_clr(clr8)
  );

  typedef struct {
    logic          rst, w, r, c;
    logic [DW-1:0] d;
    int            cnt;
    logic          en, fn, a_f, a_e, o, u;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic vec_t mk(logic rst_i, logic w_i, int d_i, logic r_i, logic c_i, int cnt_i,
                              logic en_i, logic fn_i, logic af_i, logic ae_i, logic o_i, logic u_i);
    vec_t v;
    v.rst = rst_i; v.w = w_i; v.d = DW'(d_i); v.r = r_i; v.c = c_i; v.cnt = cnt_i;
    v.en = en_i; v.fn = fn_i; v.a_f = af_i; v.a_e = ae_i; v.o = o_i; v.u = u_i;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    bit rd_ok, wr_ok;
    @(negedge clk);
    reset = v.rst; wr = v.w; din = v.d; rd = v.r; clr = v.c;
    rd_ok = v.r && exp_q.size() > 0;
    wr_ok = v.w && (exp_q.size() < 4 || rd_ok);
    @(posedge clk);
    #1;
    if (v.rst) exp_q.delete();
    else begin
      if (rd_ok) void'(exp_q.pop_front());
      if (wr_ok) exp_q.push_back(v.d);
    end
    n_vec++;
    check("count", idx, int'(count), v.cnt);
    check("empty_n", idx, int'(empty_n), int'(v.en));
    check("full_n", idx, int'(full_n), int'(v.fn));
    check("almost_full", idx, int'(af), int'(v.a_f));
    check("almost_empty", idx, int'(ae), int'(v.a_e));
    check("ovf", idx, int'(ovf), int'(v.o));
    check("udf", idx, int'(udf), int'(v.u));
    if (exp_q.size() > 0) check("dout", idx, int'(dout), int'(exp_q[0]));
  endtask

  task automatic fill4();
    vecs.push_back(mk(0,1,1,0,0, 1, 1,1,0,1, 0,0));
    vecs.push_back(mk(0,1,2,0,0, 2, 1,1,0,0, 0,0));
    vecs.push_back(mk(0,1,3,0,0, 3, 1,1,1,0, 0,0));
    vecs.push_back(mk(0,1,4,0,0, 4, 1,0,1,0, 0,0));
  endtask

  task automatic drain4();
    vecs.push_back(mk(0,0,0,1,0, 3, 1,1,1,0, 0,0));
    vecs.push_back(mk(0,0,0,1,0, 2, 1,1,0,0, 0,0));
    vecs.push_back(mk(0,0,0,1,0, 1, 1,1,0,1, 0,0));
    vecs.push_back(mk(0,0,0,1,0, 0, 0,1,0,1, 0,0));
  endtask

  initial begin
    reset = 1'b1; wr = 0; rd = 0; clr = 0; din = '0;
    reset8 = 1'b1; wr8 = 0; rd8 = 0; clr8 = 0; din8 = '0;

    // reset state, while an operation is requested
    vecs.push_back(mk(1,1,0,1,0, 0, 0,1,0,1, 0,0));
    // fill and drain in order
    fill4(); drain4();
    // read+write on full: both accepted, head advances
    fill4();
    vecs.push_back(mk(0,1,5,1,0, 4, 1,0,1,0, 0,0));
    drain4();
    // overflow, clear, clear coincident with a new refused write
    fill4();
    vecs.push_back(mk(0,1,6,0,0, 4, 1,0,1,0, 1,0));
    vecs.push_back(mk(0,0,0,0,1, 4, 1,0,1,0, 0,0));
    vecs.push_back(mk(0,1,6,0,1, 4, 1,0,1,0, 1,0));
    vecs.push_back(mk(0,0,0,0,1, 4, 1,0,1,0, 0,0));
    drain4();
    // read+write on empty: write wins, underflow raised
    vecs.push_back(mk(0,1,7,1,0, 1, 1,1,0,1, 0,1));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,1,0,1, 0,0));
    vecs.push_back(mk(0,0,0,1,0, 0, 0,1,0,1, 0,0));
    // reset during an active read+write at count 3
    vecs.push_back(mk(0,1,1,0,0, 1, 1,1,0,1, 0,0));
    vecs.push_back(mk(0,1,2,0,0, 2, 1,1,0,0, 0,0));
    vecs.push_back(mk(0,1,3,0,0, 3, 1,1,1,0, 0,0));
    vecs.push_back(mk(1,1,8,1,0, 0, 0,1,0,1, 0,0));
    vecs.push_back(mk(0,1,9,0,0, 1, 1,1,0,1, 0,0));
    vecs.push_back(mk(0,0,0,1,0, 0, 0,1,0,1, 0,0));
    // underflow on plain empty read, then a random mix on the scoreboard
    vecs.push_back(mk(0,0,0,1,0, 0, 0,1,0,1, 0,1));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,1,0,1, 0,0));

    foreach (vecs[i]) apply(vecs[i], i);

    // random writes/reads on the scoreboard: data order and count vs model size
    for (int i = 0; i < 40; i++) begin
      bit rd_ok, wr_ok;
      @(negedge clk);
      reset = 0; clr = 1'b1;
      wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      din = DW'($urandom_range(0, 255));
      rd_ok = rd && exp_q.size() > 0;
      wr_ok = wr && (exp_q.size() < 4 || rd_ok);
      @(posedge clk);
      #1;
      if (rd_ok) void'(exp_q.pop_front());
      if (wr_ok) exp_q.push_back(din);
      n_vec++;
      check("rand_count", i, int'(count), exp_q.size());
      check("rand_empty_n", i, int'(empty_n), int'(exp_q.size() != 0));
      check("rand_full_n", i, int'(full_n), int'(exp_q.size() != 4));
      if (exp_q.size() > 0) check("rand_dout", i, int'(dout), int'(exp_q[0]));
    end
    @(negedge clk);
    wr = 0; rd = 0; clr = 0;

    // DEPTH=8, FULL_RW_EN=0: thresholds, then read+write on full refuses the write
    @(negedge clk);
    reset8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      wr8 = 1'b1; din8 = DW'(i);
      @(posedge clk);
      #1;
      n_vec++;
      check("d8_count", i, int'(count8), i);
      check("d8_almost_empty", i, int'(ae8), int'(i <= 2));
      check("d8_almost_full", i, int'(af8), int'(i >= 6));
      check("d8_full_n", i, int'(full_n8), int'(i != 8));
      check("d8_dout", i, int'(dout8), 1);
    end
    @(negedge clk);
    wr8 = 1'b1; rd8 = 1'b1; din8 = 8'd99;
    @(posedge clk);
    #1;
    n_vec++;
    check("d8_rw_count", 0, int'(count8), 7);
    check("d8_rw_ovf", 0, int'(ovf8), 1);
    check("d8_rw_full_n", 0, int'(full_n8), 1);
    check("d8_rw_dout", 0, int'(dout8), 2);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      wr8 = 1'b0; rd8 = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      check("d8_drain_count", i, int'(count8), 8 - i);
      if (i < 8) check("d8_drain_dout", i, int'(dout8), i + 1);
    end
    @(negedge clk);
    rd8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
